// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment scan driver.
// Segment vectors are active-low, bit0=a ... bit6=g.
package seg7_pkg;

   typedef logic [6:0] seg_t;

   localparam int   MAX_DIGITS = 8;
   localparam seg_t SEG_BLANK  = 7'b1111111;

   localparam seg_t HEX_SEG [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // Mask of leading-zero digits, scanning from digit n-1 downward.
   // Digit 0 is never part of the mask.
   function automatic logic [MAX_DIGITS-1:0] lz_mask(
      input logic [4*MAX_DIGITS-1:0] v,
      input int                      n
   );
      logic run;
      run     = 1'b1;
      lz_mask = '0;
      for (int k = MAX_DIGITS-1; k >= 1; k--) begin
         if (k < n) begin
            run        = run & (v[4*k +: 4] == 4'h0);
            lz_mask[k] = run;
         end
      end
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble to active-low segment pattern.
// Pure lookup into the shared table; one instance serves all digits.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   output seg_t       seg
);

   // Table lookup on the currently selected nibble.
   always_comb begin
      seg = HEX_SEG[nib];
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered multiplexed 7-seg driver.
// Define SEG7_LZ_SUPPRESS_EN to blank leading zero digits.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 50000
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     blank,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  load,
   output seg_t                  seg_n,
   output logic                  dp_n,
   output logic [DIGITS-1:0]     an_n,
   output logic                  frame_tick
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
   localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

   logic [PW-1:0]         presc;
   logic [IW-1:0]         idx;
   logic [IW-1:0]         idx_nxt;
   logic                  wrap;
   logic                  commit;

   logic [4*DIGITS-1:0]   sh_val;
   logic [DIGITS-1:0]     sh_blank;
   logic [DIGITS-1:0]     sh_dp;

   logic [4*DIGITS-1:0]   act_val;
   logic [DIGITS-1:0]     act_blank;
   logic [DIGITS-1:0]     act_dp;

   logic [4*DIGITS-1:0]   nxt_val;
   logic [DIGITS-1:0]     nxt_blank;
   logic [DIGITS-1:0]     nxt_dp;

   logic [3:0]            nib;
   seg_t                  dec_seg;
   logic                  sup;
   logic                  dark;
   logic                  dp_on;
   logic [DIGITS-1:0]     one_hot;

`ifdef SEG7_LZ_SUPPRESS_EN
   logic [MAX_DIGITS-1:0] lzm;
`endif

   // Scan position and the frame-boundary commit strobe.
   always_comb begin
      wrap    = (presc == PMAX);
      commit  = wrap && (idx == IMAX);
      idx_nxt = idx;
      if (wrap) begin
         if (idx == IMAX)
            idx_nxt = '0;
         else
            idx_nxt = idx + IW'(1);
      end
   end

   // Outputs are built from the post-edge view of the active buffer,
   // so the first digit of a new frame already shows committed data.
   always_comb begin
      nxt_val   = act_val;
      nxt_blank = act_blank;
      nxt_dp    = act_dp;
      if (commit) begin
         nxt_val   = sh_val;
         nxt_blank = sh_blank;
         nxt_dp    = sh_dp;
      end
   end

   // Select the nibble and per-digit controls for the next digit.
   always_comb begin
      nib          = nxt_val[{idx_nxt, 2'b00} +: 4];
      one_hot      = '0;
      one_hot[idx_nxt] = 1'b1;
`ifdef SEG7_LZ_SUPPRESS_EN
      lzm          = lz_mask((4*MAX_DIGITS)'(nxt_val), DIGITS);
      sup          = lzm[idx_nxt];
`else
      sup          = 1'b0;
`endif
      dark         = nxt_blank[idx_nxt] | sup;
      dp_on        = nxt_dp[idx_nxt] & ~nxt_blank[idx_nxt];
   end

   seg7_hex_decode u_dec (
      .nib (nib),
      .seg (dec_seg)
   );

   // Prescaler and digit index.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         presc <= '0;
         idx   <= '0;
      end else begin
         presc <= wrap ? '0 : presc + PW'(1);
         idx   <= idx_nxt;
      end
   end

   // Shadow buffer captures host writes; last load in a frame wins.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         sh_val   <= '0;
         sh_blank <= '0;
         sh_dp    <= '0;
      end else if (load) begin
         sh_val   <= value;
         sh_blank <= blank;
         sh_dp    <= dp;
      end
   end

   // Active buffer takes the shadow only at the frame boundary.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         act_val   <= '0;
         act_blank <= '0;
         act_dp    <= '0;
      end else begin
         act_val   <= nxt_val;
         act_blank <= nxt_blank;
         act_dp    <= nxt_dp;
      end
   end

   // Registered pin drivers, updated on the same edge as idx.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         seg_n      <= SEG_BLANK;
         dp_n       <= 1'b1;
         an_n       <= '1;
         frame_tick <= 1'b0;
      end else begin
         seg_n      <= dark ? SEG_BLANK : dec_seg;
         dp_n       <= ~dp_on;
         an_n       <= ~one_hot;
         frame_tick <= commit;
      end
   end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits.
- Decodes full hex (0–F) per digit and scans the digits one at a time at a programmable rate.
- Double-buffers the displayed value so an update never tears mid-frame.
- Provides per-digit blanking and decimal-point control.
- Sits between game/status logic and the board's shared segment bus; replaces per-digit static decoders.

## Interface
Parameters:
- DIGITS, 4: number of digits scanned (1..8).
- PRESCALE, 50000: clock cycles each digit is driven (≥2).

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- value  in  4*DIGITS  hex nibbles; nibble k = value[4k+3:4k] drives digit k; digit 0 is least significant.
- blank  in  DIGITS  1 = digit k dark (segments and dp off, anode still scanned).
- dp  in  DIGITS  1 = decimal point of digit k lit.
- load  in  1  single-cycle strobe; captures value/blank/dp into the shadow register.
- seg_n  out  7  active-low segments; bit0=a, bit1=b … bit6=g.
- dp_n  out  1  active-low decimal point.
- an_n  out  DIGITS  active-low one-hot anode select.
- frame_tick  out  1  one-cycle pulse when a new frame begins with freshly committed data.

## Operation
- Registers:
  - shadow (value/blank/dp): written on load.
  - active: drives the display.
  - presc counter: 0..PRESCALE-1.
  - digit index idx: 0..DIGITS-1.
- presc increments every cycle and wraps to 0 at PRESCALE-1. On that wrap, idx advances and wraps DIGITS-1 → 0.
- Commit: on the cycle presc==PRESCALE-1 and idx==DIGITS-1, active ← shadow.
- load in the same cycle as a commit: shadow takes the new inputs; active takes the previous shadow contents. The new data appears one frame later.
- Multiple loads within one frame: only the last is committed.
- Decode table (seg_n, hex 0–F):
  - 0–7: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000.
  - 8–F: 0000000, 0011000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Blanked digit: seg_n=1111111, dp_n=1; an_n still selects it, so brightness stays uniform.
- Reset values: seg_n=1111111, dp_n=1, an_n all ones, frame_tick=0, presc=0, idx=0, shadow=0, active=0 with blank=0.

## Timing
- seg_n, dp_n and an_n are registered and change on the same edge as idx. No combinational path from inputs to outputs.
- First edge after resetN rises: an_n selects digit 0 and shows active digit 0 ("0" after reset).
- Each digit is held exactly PRESCALE cycles; one frame = DIGITS*PRESCALE cycles.
- load → visible: ≤ 1 frame + 1 cycle.
- frame_tick is high for the one cycle in which idx==0 and presc==0 following a commit. No frame_tick precedes the first wrap after reset.
- resetN asserted mid-frame: all outputs go inactive immediately (asynchronously). Pending shadow data is discarded.
- DIGITS==1: idx is constant 0; a commit occurs every PRESCALE cycles.

## Configuration
- Macro SEG7_LZ_SUPPRESS_EN controls leading-zero suppression.
- Defined: zero digits are blanked when they are, and every digit above them is, zero. This runs from digit DIGITS-1 downward, evaluated on active. Digit 0 is never suppressed. dp of a suppressed digit still follows dp.
- Undefined: all non-blanked digits display their nibble, including leading zeros.

## Structure
- Package seg7_pkg holds:
  - SEG_BLANK constant (7'b1111111).
  - The 16-entry hex segment table as a constant array.
  - The seg_t typedef (logic [6:0]).
- Sub-module seg7_hex_decode: combinational 4-bit nibble → seg_t lookup using the package table. Instantiated once on the muxed nibble, not once per digit.

## Test plan
Configuration for all tests: DIGITS=4, PRESCALE=4.
- Reset then idle → an_n cycles 1110, 1101, 1011, 0111 every 4 cycles; seg_n=1000000 on every digit; frame_tick stays 0 until the first wrap.
- load value=16'hA3F1 mid-frame → current frame unchanged. Next frame shows digit0=1111001, digit1=0001110, digit2=0110000, digit3=0001000; frame_tick pulses at its start.
- load on the commit cycle with value=16'h1234, shadow previously 16'h5555 → next frame shows 5555; the following frame shows 1234.
- blank=4'b0100, dp=4'b0001 → digit2 seg_n=1111111, dp_n=1; digit0 dp_n=0; all anodes still scanned.
- With SEG7_LZ_SUPPRESS_EN, value=16'h0070 → digits 3 and 2 blank, digit1=1111000, digit0=1000000. Without the macro → digits 3 and 2 show 1000000.
- resetN pulsed low at presc=2, idx=2 → outputs inactive within the same cycle; after release, scan restarts at digit 0 showing 0.
